// File: rtl/masked_sbox_driver_if.sv
// Bundle of the request, PRNG, S-box and result signals around the masked S-box driver.
// The 'slave' modport is the driver block; 'master' is everything around it
// (upstream requester, PRNG, S-box and downstream consumer).
interface masked_sbox_driver_if #(
  parameter int unsigned SHARES  = 4,
  parameter int unsigned NIB     = 4,
  parameter int unsigned FRESH_W = 102
);
  logic                    in_valid;
  logic                    in_ready;
  logic [SHARES*NIB-1:0]   in_shares;
  logic                    rnd_valid;
  logic [FRESH_W-1:0]      rnd_data;
  logic                    rnd_req;
  logic [SHARES*NIB-1:0]   sb_x;
  logic [FRESH_W-1:0]      sb_fresh;
  logic                    sb_rst;
  logic                    sb_synch;
  logic [SHARES*NIB-1:0]   sb_y;
  logic                    out_valid;
  logic                    out_ready;
  logic [SHARES*NIB-1:0]   out_shares;
  logic                    err;

  modport slave (
    input  in_valid, in_shares, rnd_valid, rnd_data, sb_synch, sb_y, out_ready,
    output in_ready, rnd_req, sb_x, sb_fresh, sb_rst, out_valid, out_shares, err
  );

  modport master (
    output in_valid, in_shares, rnd_valid, rnd_data, sb_synch, sb_y, out_ready,
    input  in_ready, rnd_req, sb_x, sb_fresh, sb_rst, out_valid, out_shares, err
  );
endinterface

// File: rtl/masked_sbox_driver.sv
// Initiator-side sequencer for a 4-share HPC2 masked Skinny S-box.
// Holds the X shares stable, streams fresh randomness, releases the S-box clock-gating
// reset, waits for Synch, and hands the Y shares downstream. All paths are share-wise.
module masked_sbox_driver #(
  parameter int unsigned SHARES  = 4,
  parameter int unsigned NIB     = 4,
  parameter int unsigned FRESH_W = 102,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  masked_sbox_driver_if.slave  bus
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StBusy, StDone} state_e;

  state_e                r_state;
  logic [WdogW-1:0]      r_wdog;
  logic                  r_rnd_req;
  logic                  r_sb_rst;
  logic                  r_out_valid;
  logic                  r_err;
  logic [SHARES*NIB-1:0] r_sb_x;
  logic [SHARES*NIB-1:0] r_out_shares;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_wdog_sat;
  logic                  w_wdog_last;

  // Accept only when a PRNG word is already available, so LOAD never starts starved.
  assign w_idle      = (r_state == StIdle);
  assign w_accept    = w_idle && bus.in_valid && bus.rnd_valid;
  assign w_wdog_sat  = (r_wdog == {WdogW{1'b1}});
  assign w_wdog_last = (r_wdog == WdogW'(TIMEOUT - 1));

  // Output drive: fresh randomness is gated to zero whenever the S-box is not consuming it.
  assign bus.in_ready   = w_idle && bus.rnd_valid;
  assign bus.rnd_req    = r_rnd_req;
  assign bus.sb_fresh   = r_rnd_req ? bus.rnd_data : '0;
  assign bus.sb_rst     = r_sb_rst;
  assign bus.sb_x       = r_sb_x;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_shares = r_out_shares;
  assign bus.err        = r_err;

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_wdog       <= '0;
      r_rnd_req    <= 1'b0;
      r_sb_rst     <= 1'b1;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_sb_x       <= '0;
      r_out_shares <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sb_x    <= bus.in_shares;
            r_err     <= 1'b0;
            r_rnd_req <= 1'b1;
            r_state   <= StLoad;
          end
        end
        StLoad: begin
          r_wdog   <= '0;
          r_sb_rst <= 1'b0;
          r_state  <= StBusy;
        end
        StBusy: begin
          if (!w_wdog_sat) begin
            r_wdog <= r_wdog + WdogW'(1);
          end
          if (bus.sb_synch) begin
            r_out_shares <= bus.sb_y;
            r_out_valid  <= 1'b1;
            r_sb_rst     <= 1'b1;
            r_rnd_req    <= 1'b0;
            r_state      <= StDone;
          end else if (!bus.rnd_valid || w_wdog_last) begin
            // Starvation or watchdog expiry: abort without producing a result.
            r_err     <= 1'b1;
            r_sb_rst  <= 1'b1;
            r_rnd_req <= 1'b0;
            r_state   <= StIdle;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_masked_sbox_driver.sv
// Self-checking bench for masked_sbox_driver with a behavioural masked Skinny S-box model.
module tb_masked_sbox_driver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  masked_sbox_driver_if bus ();

  masked_sbox_driver dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // S-box model: Synch in the 9th cycle out of reset; Y re-masked share-wise.
  function automatic logic [3:0] skinny(input logic [3:0] x);
    case (x)
      4'h0: skinny = 4'hc;  4'h1: skinny = 4'h6;  4'h2: skinny = 4'h9;  4'h3: skinny = 4'h0;
      4'h4: skinny = 4'h1;  4'h5: skinny = 4'ha;  4'h6: skinny = 4'h2;  4'h7: skinny = 4'hb;
      4'h8: skinny = 4'h3;  4'h9: skinny = 4'h8;  4'ha: skinny = 4'h5;  4'hb: skinny = 4'hd;
      4'hc: skinny = 4'h4;  4'hd: skinny = 4'he;  4'he: skinny = 4'h7;  default: skinny = 4'hf;
    endcase
  endfunction

  logic [4:0] m_cnt;
  logic       synch_en;
  logic [3:0] m_x;

  always @(posedge clk) begin
    if (bus.sb_rst) m_cnt <= 5'd0;
    else if (m_cnt != 5'd31) m_cnt <= m_cnt + 5'd1;
  end

  assign bus.sb_synch = synch_en && !bus.sb_rst && (m_cnt == 5'd8);
  assign m_x = bus.sb_x[3:0] ^ bus.sb_x[7:4] ^ bus.sb_x[11:8] ^ bus.sb_x[15:12];
  assign bus.sb_y = {bus.sb_x[15:12] ^ 4'h6, bus.sb_x[11:8] ^ 4'h6, bus.sb_x[7:4] ^ 4'h6,
                     skinny(m_x) ^ bus.sb_x[15:12] ^ bus.sb_x[11:8] ^ bus.sb_x[7:4] ^ 4'h6};

  // PRNG model: new word every negedge so it never races the sampling point.
  initial begin
    logic [127:0] tmp;
    bus.rnd_data = '0;
    forever begin
      @(negedge clk);
      tmp = {$urandom, $urandom, $urandom, $urandom};
      bus.rnd_data = tmp[101:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a request and return in the LOAD cycle (1 ns after the accepting edge).
  task automatic send(input logic [15:0] sh);
    int guard;
    guard = 0;
    bus.in_shares = sh;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", 32'(guard < 20), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // From the LOAD cycle: wait for the result, check it, hold in DONE, then release.
  task automatic finish(input logic [15:0] sh, input logic [3:0] exp_y, input int hold);
    int          cyc;
    logic        ok;
    logic [15:0] snap;
    logic [3:0]  y;
    cyc = 1;
    ok  = 1'b1;
    while (!bus.out_valid && cyc < 40) begin
      if (!bus.sb_rst && (bus.sb_x !== sh || bus.sb_fresh !== bus.rnd_data || !bus.rnd_req))
        ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd11);
    check("busy_hold", 32'(ok), 32'd1);
    y = bus.out_shares[3:0] ^ bus.out_shares[7:4] ^ bus.out_shares[11:8] ^ bus.out_shares[15:12];
    check("sbox_y", 32'(y), 32'(exp_y));
    check("err_clear", 32'(bus.err), 32'd0);
    snap = bus.out_shares;
    ok   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (bus.out_shares !== snap || bus.in_ready || bus.sb_fresh !== '0 || !bus.out_valid ||
          !bus.sb_rst) ok = 1'b0;
      @(posedge clk); #1;
    end
    if (hold > 0) check("done_hold", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("done_exit", 32'({bus.out_valid, bus.rnd_req, bus.sb_rst, bus.in_ready}), 32'b0011);
  endtask

  typedef struct {
    logic [15:0] shares;
    logic [3:0]  exp_y;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    int   busy;
    int   g;

    // Shares {s0, 0xA, 0x5, 0xC}; s0 = x ^ 0x3 so the unmasked value is x.
    vecs[0]  = '{16'hC5A3, 4'hc};  vecs[1]  = '{16'hC5A2, 4'h6};
    vecs[2]  = '{16'hC5A1, 4'h9};  vecs[3]  = '{16'hC5A0, 4'h0};
    vecs[4]  = '{16'hC5A7, 4'h1};  vecs[5]  = '{16'hC5A6, 4'ha};
    vecs[6]  = '{16'hC5A5, 4'h2};  vecs[7]  = '{16'hC5A4, 4'hb};
    vecs[8]  = '{16'hC5AB, 4'h3};  vecs[9]  = '{16'hC5AA, 4'h8};
    vecs[10] = '{16'hC5A9, 4'h5};  vecs[11] = '{16'hC5A8, 4'hd};
    vecs[12] = '{16'hC5AF, 4'h4};  vecs[13] = '{16'hC5AE, 4'he};
    vecs[14] = '{16'hC5AD, 4'h7};  vecs[15] = '{16'hC5AC, 4'hf};

    bus.in_valid  = 1'b0;
    bus.in_shares = '0;
    bus.rnd_valid = 1'b1;
    bus.out_ready = 1'b0;
    synch_en      = 1'b1;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 32'({bus.sb_rst, bus.rnd_req, bus.out_valid, bus.err}), 32'b1000);
    check("rst_sb_x", 32'(bus.sb_x), 32'd0);
    check("rst_out", 32'(bus.out_shares), 32'd0);
    check("rst_fresh", 32'(bus.sb_fresh == '0), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic transaction on value 0.
    send(vecs[0].shares);
    finish(vecs[0].shares, vecs[0].exp_y, 0);

    // No PRNG word in IDLE: no accept until rnd_valid rises.
    bus.rnd_valid = 1'b0;
    bus.in_shares = vecs[5].shares;
    bus.in_valid  = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.in_ready || bus.rnd_req || !bus.sb_rst) ok = 1'b0;
    end
    check("idle_starve", 32'(ok), 32'd1);
    bus.rnd_valid = 1'b1;
    #1;
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("load_after", 32'({bus.rnd_req, bus.sb_rst}), 32'b11);
    check("load_sb_x", 32'(bus.sb_x), 32'(vecs[5].shares));
    finish(vecs[5].shares, vecs[5].exp_y, 0);

    // Starvation at BUSY cycle 4.
    send(vecs[3].shares);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    bus.rnd_valid = 1'b0;
    @(posedge clk); #1;
    bus.rnd_valid = 1'b1;
    check("starve_abort", 32'({bus.err, bus.sb_rst, bus.out_valid, bus.rnd_req}), 32'b1100);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("starve_no_out", 32'(ok), 32'd1);
    send(vecs[9].shares);
    check("err_cleared", 32'(bus.err), 32'd0);
    finish(vecs[9].shares, vecs[9].exp_y, 0);

    // Synch never arrives: watchdog aborts after 16 BUSY cycles.
    synch_en = 1'b0;
    send(vecs[2].shares);
    busy = 0;
    g    = 0;
    while (!bus.err && g < 60) begin
      if (!bus.sb_rst) busy++;
      @(posedge clk); #1;
      g++;
    end
    check("timeout_cycles", 32'(busy), 32'd16);
    check("timeout_state",
          32'({bus.err, bus.sb_rst, bus.in_ready, bus.out_valid, bus.rnd_req}), 32'b11100);
    synch_en = 1'b1;

    // Result held in DONE while downstream stalls.
    send(vecs[7].shares);
    finish(vecs[7].shares, vecs[7].exp_y, 5);

    // Reset asserted at BUSY cycle 3.
    send(vecs[4].shares);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({bus.sb_rst, bus.rnd_req, bus.out_valid, bus.err}), 32'b1000);
    check("midrst_sb_x", 32'(bus.sb_x), 32'd0);
    check("midrst_out", 32'(bus.out_shares), 32'd0);
    check("midrst_fresh", 32'(bus.sb_fresh == '0), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // All 16 S-box inputs.
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].shares);
      finish(vecs[i].shares, vecs[i].exp_y, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
